// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit.
package shift_pkg;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_LSL = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Purpose: shift/rotate a WIDTH-bit value by k_i (0..STEP) positions for one mode.
// Latency: combinational.
// Backpressure: none, pure datapath.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIST_W = 4
) (
    input  logic [WIDTH-1:0]  val_i,
    input  logic [1:0]        mode_i,
    input  logic [DIST_W-1:0] k_i,
    output logic [WIDTH-1:0]  res_o
);

    always_comb begin
        res_o = val_i;
        case (mode_i)
            MODE_LSR: res_o = val_i >> k_i;
            MODE_LSL: res_o = val_i << k_i;
            MODE_ASR: res_o = $signed(val_i) >>> k_i;
            // Doubling the word lets the rotate fall out of a plain right shift.
            default:  res_o = WIDTH'({val_i, val_i} >> k_i);
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Purpose: handshaked LSR/LSL/ASR/ROR unit, STEP bit positions per cycle.
// Latency: ceil(eff/STEP) cycles after accept; eff==0 is valid on the accepting edge.
// Backpressure: holds result in DONE until out_ready; accepts only in IDLE.
module shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int STEP   = 1,
    localparam int DIST_W = $clog2(WIDTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [DIST_W-1:0] distance,
    input  logic [WIDTH-1:0]  data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic              busy
);

    localparam logic [DIST_W-1:0] WIDTH_V = DIST_W'(WIDTH);
    localparam logic [DIST_W-1:0] STEP_V  = DIST_W'(STEP);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [DIST_W-1:0] rem_q, rem_d;
    logic [1:0]        mode_q, mode_d;
    logic [DIST_W-1:0] eff;
    logic [DIST_W-1:0] k;
    logic [WIDTH-1:0]  step_res;

    // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH (all fill bits).
    always_comb begin
        if (mode == MODE_ROR) begin
            eff = {1'b0, distance[DIST_W-2:0]};
        end else if (distance >= WIDTH_V) begin
            eff = WIDTH_V;
        end else begin
            eff = distance;
        end
    end

    assign k = (rem_q < STEP_V) ? rem_q : STEP_V;

    shift_step #(
        .WIDTH  (WIDTH),
        .DIST_W (DIST_W)
    ) u_step (
        .val_i  (acc_q),
        .mode_i (mode_q),
        .k_i    (k),
        .res_o  (step_res)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = data_in;
                    mode_d  = mode;
                    rem_d   = eff;
                    state_d = (eff == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = step_res;
                rem_d = rem_q - k;
                if (rem_q == k) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_LSR;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign data_out  = acc_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: WIDTH=8 with STEP=1 and STEP=2 instances.
module tb_shift_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0] mode;
    logic [3:0] distance;
    logic [7:0] data_in, data_out;

    logic       rst2_n;
    logic       in_valid2, in_ready2, out_valid2, busy2;
    logic [1:0] mode2;
    logic [3:0] distance2;
    logic [7:0] data_in2, data_out2;

    logic [7:0] sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    shift_unit #(.WIDTH(8), .STEP(1)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .distance(distance), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    shift_unit #(.WIDTH(8), .STEP(2)) dut2 (
        .clock(clock), .reset_n(rst2_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .mode(mode2), .distance(distance2), .data_in(data_in2), .out_valid(out_valid2),
        .out_ready(1'b1), .data_out(data_out2), .busy(busy2)
    );

    // Bit-at-a-time reference model.
    function automatic logic [7:0] model(input logic [1:0] m, input int d, input logic [7:0] v);
        int e;
        e = (m == 2'b11) ? (d % 8) : ((d > 8) ? 8 : d);
        for (int i = 0; i < e; i++) begin
            case (m)
                2'b00:   v = {1'b0, v[7:1]};
                2'b01:   v = {v[6:0], 1'b0};
                2'b10:   v = {v[7], v[7:1]};
                default: v = {v[0], v[7:1]};
            endcase
        end
        return v;
    endfunction

    function automatic int eff_of(input logic [1:0] m, input int d);
        return (m == 2'b11) ? (d % 8) : ((d > 8) ? 8 : d);
    endfunction

    // Drive one request from posedge+#1, return after the accepting edge (+#1).
    task automatic issue(input logic [1:0] m, input logic [3:0] d, input logic [7:0] v,
                         input logic [7:0] exp);
        sb_q.push_back(exp);
        mode = m; distance = d; data_in = v; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        mode = 2'($urandom); distance = 4'($urandom); data_in = 8'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out got %h want 00", data_out); end
    endtask

    task automatic test_lsr;
        int lat;
        logic [7:0] exp;
        issue(2'b00, 4'd3, 8'b1011_0110, 8'b0001_0110);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lsr_busy got %b want 1", busy); end
        wait_valid(lat);
        exp = sb_q.pop_front();
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lsr_latency got %0d want 3", lat); end
        n_cmp++; if (data_out !== exp) begin n_bad++; $display("FAIL lsr_data got %h want %h", data_out, exp); end
        @(posedge clock); #1;
    endtask

    task automatic test_saturate;
        int lat;
        logic [7:0] exp;
        issue(2'b10, 4'd9, 8'h96, 8'hFF);
        wait_valid(lat);
        exp = sb_q.pop_front();
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL asr9_latency got %0d want 8", lat); end
        n_cmp++; if (data_out !== exp) begin n_bad++; $display("FAIL asr9_data got %h want %h", data_out, exp); end
        @(posedge clock); #1;
        issue(2'b01, 4'd9, 8'h96, 8'h00);
        wait_valid(lat);
        exp = sb_q.pop_front();
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL lsl9_latency got %0d want 8", lat); end
        n_cmp++; if (data_out !== exp) begin n_bad++; $display("FAIL lsl9_data got %h want %h", data_out, exp); end
        @(posedge clock); #1;
    endtask

    task automatic test_ror;
        int lat;
        logic [7:0] exp;
        issue(2'b11, 4'd9, 8'h81, 8'hC0);
        wait_valid(lat);
        exp = sb_q.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ror9_latency got %0d want 1", lat); end
        n_cmp++; if (data_out !== exp) begin n_bad++; $display("FAIL ror9_data got %h want %h", data_out, exp); end
        @(posedge clock); #1;
        issue(2'b11, 4'd8, 8'h81, 8'h81);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ror8_valid_on_accept got %b want 1", out_valid); end
        exp = sb_q.pop_front();
        n_cmp++; if (data_out !== exp) begin n_bad++; $display("FAIL ror8_data got %h want %h", data_out, exp); end
        @(posedge clock); #1;
    endtask

    task automatic test_zero_dist;
        logic [7:0] v, exp;
        for (int m = 0; m < 4; m++) begin
            v = 8'($urandom);
            issue(2'(m), 4'd0, v, v);
            exp = sb_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1 || data_out !== exp) begin
                n_bad++; $display("FAIL zero_dist_m%0d got v=%b d=%h want v=1 d=%h", m, out_valid, data_out, exp);
            end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_dist_ready_low_m%0d got %b want 0", m, in_ready); end
            @(posedge clock); #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_dist_ready_back_m%0d got %b want 1", m, in_ready); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [7:0] exp;
        out_ready = 1'b0;
        issue(2'b01, 4'd2, 8'h35, 8'hD4);
        wait_valid(lat);
        exp = sb_q.pop_front();
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_latency got %0d want 2", lat); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; data_in = 8'($urandom); distance = 4'd1; mode = 2'b00;
            @(posedge clock); #1;
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== exp) begin
                n_bad++; $display("FAIL bp_hold_c%0d got v=%b r=%b d=%h want v=1 r=0 d=%h", c, out_valid, in_ready, data_out, exp);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int lat, d;
        logic [1:0] m;
        logic [7:0] v, exp;
        for (int i = 0; i < 10; i++) begin
            m = 2'($urandom);
            d = $urandom_range(0, 15);
            v = 8'($urandom);
            issue(m, 4'(d), v, model(m, d, v));
            if (eff_of(m, d) != 0) wait_valid(lat); else lat = 0;
            exp = sb_q.pop_front();
            n_cmp++; if (lat !== eff_of(m, d) || data_out !== exp) begin
                n_bad++; $display("FAIL b2b_%0d m=%0d d=%0d got lat=%0d data=%h want lat=%0d data=%h",
                                  i, m, d, lat, data_out, eff_of(m, d), exp);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_step2_reset;
        int lat;
        logic [7:0] exp;
        mode2 = 2'b01; distance2 = 4'd5; data_in2 = 8'h01; in_valid2 = 1'b1;
        @(posedge clock); #1;
        in_valid2 = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        rst2_n = 1'b0;
        #1;
        n_cmp++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || busy2 !== 1'b0 || data_out2 !== 8'h00) begin
            n_bad++; $display("FAIL step2_async_reset got r=%b v=%b b=%b d=%h want r=1 v=0 b=0 d=00",
                              in_ready2, out_valid2, busy2, data_out2);
        end
        @(negedge clock);
        rst2_n = 1'b1;
        @(posedge clock); #1;
        sb_q.push_back(8'h20);
        mode2 = 2'b01; distance2 = 4'd5; data_in2 = 8'h01; in_valid2 = 1'b1;
        @(posedge clock); #1;
        in_valid2 = 1'b0; distance2 = 4'd1;
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        exp = sb_q.pop_front();
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL step2_latency got %0d want 3", lat); end
        n_cmp++; if (data_out2 !== exp) begin n_bad++; $display("FAIL step2_data got %h want %h", data_out2, exp); end
    endtask

    initial begin
        reset_n = 1'b0; rst2_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; distance = 4'd0; data_in = 8'h00;
        in_valid2 = 1'b0; mode2 = 2'b00; distance2 = 4'd0; data_in2 = 8'h00;
        #12;
        reset_n = 1'b1; rst2_n = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_lsr();
        test_saturate();
        test_ror();
        test_zero_dist();
        test_backpressure();
        test_back_to_back();
        test_step2_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
